diffusion_step_sequencer: RTL and testbench

- Global step controller for the PARALLEL diffusion_rw engines and their add_up_score units.
- Sequences each lap in order: launch, propagation, score add-up, step advance.
- Aggregates the per-engine finished / finished_final flags with sticky capture, so engines finishing at different cycles are handled.
- Replaces the hard-wired 8-input step counter and AND-reduction; adds a start/done handshake and a per-phase watchdog.

---
 rtl/diffusion_step_sequencer_if.sv | 27 ++
 rtl/diffusion_step_sequencer.sv | 143 ++++++++++++++
 tb/tb_diffusion_step_sequencer.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/diffusion_step_sequencer_if.sv
// Control bundle between the step sequencer and the parallel diffusion_rw /
// add_up_score lanes: per-lane completion flags in, enables and lap status out.
interface diffusion_step_sequencer_if #(
    parameter int PARALLEL   = 8,
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [PARALLEL-1:0]   finished;
    logic [PARALLEL-1:0]   finished_final;
    logic [PARALLEL-1:0]   rdy;
    logic [DATA_WIDTH-1:0] l_step;
    logic                  finished_propagation;
    logic                  finished_all;
    logic                  busy;
    logic                  done;
    logic                  error;

    modport master (
        input  start, finished, finished_final,
        output rdy, l_step, finished_propagation, finished_all, busy, done, error
    );

    modport slave (
        output start, finished, finished_final,
        input  rdy, l_step, finished_propagation, finished_all, busy, done, error
    );
endinterface

// File: rtl/diffusion_step_sequencer.sv
// Global lap sequencer: launch, propagate, add up, advance; sticky capture of
// per-lane completion flags and a per-phase watchdog.
module diffusion_step_sequencer #(
    parameter int          PARALLEL      = 8,
    parameter int          DATA_WIDTH    = 32,
    parameter int          max_steps     = 7,
    parameter int          TIMEOUT_WIDTH = 16,
    parameter int unsigned TIMEOUT       = 50000
) (
    input  logic                         clk,
    input  logic                         rst,
    diffusion_step_sequencer_if.master   bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_PROP, S_ADDUP, S_SYNC, S_DONE, S_ERROR
    } state_e;

    localparam logic [DATA_WIDTH-1:0]    LAST_STEP = DATA_WIDTH'(max_steps - 1);
    localparam logic [TIMEOUT_WIDTH-1:0] WD_LAST   =
        TIMEOUT_WIDTH'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_e                   state_q;
    logic [PARALLEL-1:0]      prop_seen_q, fin_seen_q, rdy_q;
    logic [PARALLEL-1:0]      prop_seen_d, fin_seen_d;
    logic [DATA_WIDTH-1:0]    l_step_q;
    logic [TIMEOUT_WIDTH-1:0] wd_q, wd_d;
    logic                     fp_q, fa_q, busy_q, done_q, error_q;
    logic                     wd_expired;

    always_comb begin
        prop_seen_d = prop_seen_q | bus.finished;
        fin_seen_d  = fin_seen_q | bus.finished_final;
        wd_d        = (&wd_q) ? wd_q : wd_q + 1'b1;
        wd_expired  = (TIMEOUT != 0) && (wd_q == WD_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            prop_seen_q <= '0;
            fin_seen_q  <= '0;
            rdy_q       <= '0;
            l_step_q    <= '0;
            wd_q        <= '0;
            fp_q        <= 1'b0;
            fa_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_q  <= S_LAUNCH;
                        l_step_q <= '0;
                        busy_q   <= 1'b1;
                    end
                end
                S_LAUNCH: begin
                    prop_seen_q <= '0;
                    fin_seen_q  <= '0;
                    wd_q        <= '0;
                    rdy_q       <= '1;
                    fp_q        <= 1'b0;
                    fa_q        <= 1'b0;
                    state_q     <= S_PROP;
                end
                S_PROP: begin
                    prop_seen_q <= prop_seen_d;
                    // completion in the same cycle as watchdog expiry still counts
                    if (&prop_seen_d) begin
                        state_q <= S_ADDUP;
                        fp_q    <= 1'b1;
                        rdy_q   <= ~fin_seen_q;
                        wd_q    <= '0;
                    end else if (wd_expired) begin
                        state_q <= S_ERROR;
                        error_q <= 1'b1;
                        rdy_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                        wd_q    <= '0;
                    end else begin
                        rdy_q <= ~prop_seen_d;
                        wd_q  <= wd_d;
                    end
                end
                S_ADDUP: begin
                    fin_seen_q <= fin_seen_d;
                    if (&fin_seen_d) begin
                        state_q <= S_SYNC;
                        fa_q    <= 1'b1;
                        rdy_q   <= '0;
                        wd_q    <= '0;
                    end else if (wd_expired) begin
                        state_q <= S_ERROR;
                        error_q <= 1'b1;
                        rdy_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                        wd_q    <= '0;
                    end else begin
                        rdy_q <= ~fin_seen_d;
                        wd_q  <= wd_d;
                    end
                end
                S_SYNC: begin
                    fa_q <= 1'b0;
                    if (l_step_q == LAST_STEP) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        rdy_q   <= '0;
                    end else begin
                        state_q  <= S_LAUNCH;
                        l_step_q <= l_step_q + 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.start) begin
                        state_q  <= S_LAUNCH;
                        l_step_q <= '0;
                        done_q   <= 1'b0;
                        fp_q     <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end
                S_ERROR: begin
                    state_q <= S_ERROR;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.rdy                  = rdy_q;
    assign bus.l_step               = l_step_q;
    assign bus.finished_propagation = fp_q;
    assign bus.finished_all         = fa_q;
    assign bus.busy                 = busy_q;
    assign bus.done                 = done_q;
    assign bus.error                = error_q;
endmodule

// File: tb/tb_diffusion_step_sequencer.sv
// Bench for diffusion_step_sequencer: a lap-walking reference model checked
// every cycle on two instances, plus directed scenarios with literal results.
module tb_diffusion_step_sequencer;
    localparam int P  = 8;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]   rst_v;
    logic [1:0]   start_v;
    logic [P-1:0] fin_v [2];
    logic [P-1:0] ff_v  [2];

    diffusion_step_sequencer_if #(.PARALLEL(P), .DATA_WIDTH(DW)) if_a ();
    diffusion_step_sequencer_if #(.PARALLEL(P), .DATA_WIDTH(DW)) if_b ();

    assign if_a.start          = start_v[0];
    assign if_a.finished       = fin_v[0];
    assign if_a.finished_final = ff_v[0];
    assign if_b.start          = start_v[1];
    assign if_b.finished       = fin_v[1];
    assign if_b.finished_final = ff_v[1];

    diffusion_step_sequencer #(
        .PARALLEL(P), .DATA_WIDTH(DW), .max_steps(7), .TIMEOUT_WIDTH(16), .TIMEOUT(20)
    ) dut_a (.clk(clk), .rst(rst_v[0]), .bus(if_a));

    diffusion_step_sequencer #(
        .PARALLEL(P), .DATA_WIDTH(DW), .max_steps(1), .TIMEOUT_WIDTH(16), .TIMEOUT(0)
    ) dut_b (.clk(clk), .rst(rst_v[1]), .bus(if_b));

    logic [P-1:0]  exp_rdy  [2];
    logic [DW-1:0] exp_l    [2];
    logic          exp_fp   [2];
    logic          exp_fa   [2];
    logic          exp_busy [2];
    logic          exp_done [2];
    logic          exp_err  [2];

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model: walks laps as nested loops ----------------
    function automatic void set_rst(input int k);
        exp_rdy[k] = '0; exp_l[k] = '0; exp_fp[k] = 1'b0; exp_fa[k] = 1'b0;
        exp_busy[k] = 1'b0; exp_done[k] = 1'b0; exp_err[k] = 1'b0;
    endfunction

    task automatic tick(input int k, output bit r);
        @(posedge clk);
        r = rst_v[k];
        if (r) set_rst(k);
    endtask

    // res: 0 = reset hit, 1 = all laps done, 2 = watchdog error
    task automatic run(input int k, input int ms, input int to, output int res);
        bit r;
        logic [P-1:0] seen;
        int cnt;
        res = 1;
        for (int lap = 0; lap < ms; lap++) begin
            tick(k, r);
            if (r) begin res = 0; return; end
            exp_rdy[k] = '1; exp_fp[k] = 1'b0; exp_fa[k] = 1'b0;
            for (int ph = 0; ph < 2; ph++) begin
                seen = '0;
                cnt = 0;
                forever begin
                    tick(k, r);
                    if (r) begin res = 0; return; end
                    seen |= (ph == 0) ? fin_v[k] : ff_v[k];
                    if (seen == '1) break;
                    if (to != 0 && cnt == to - 1) begin
                        exp_err[k] = 1'b1; exp_rdy[k] = '0;
                        exp_busy[k] = 1'b0; exp_done[k] = 1'b0;
                        res = 2;
                        return;
                    end
                    cnt++;
                    exp_rdy[k] = ~seen;
                end
                if (ph == 0) begin exp_fp[k] = 1'b1; exp_rdy[k] = '1; end
                else begin exp_fa[k] = 1'b1; exp_rdy[k] = '0; end
            end
            tick(k, r);
            if (r) begin res = 0; return; end
            exp_fa[k] = 1'b0;
            if (lap == ms - 1) begin exp_done[k] = 1'b1; exp_busy[k] = 1'b0; end
            else exp_l[k] = DW'(lap + 1);
        end
    endtask

    task automatic walker(input int k, input int ms, input int to);
        bit r;
        int res;
        set_rst(k);
        forever begin
            tick(k, r);
            if (!r && start_v[k]) begin
                exp_busy[k] = 1'b1; exp_done[k] = 1'b0; exp_l[k] = '0; exp_fp[k] = 1'b0;
                run(k, ms, to, res);
                if (res == 2) begin
                    do tick(k, r); while (!r);
                end
            end
        end
    endtask

    initial walker(0, 7, 20);
    initial walker(1, 1, 0);

    always @(negedge clk) begin
        if (chk_en) begin
            chk("a_rdy",   32'(if_a.rdy), 32'(exp_rdy[0]));
            chk("a_lstep", if_a.l_step, exp_l[0]);
            chk("a_fprop", 32'(if_a.finished_propagation), 32'(exp_fp[0]));
            chk("a_fall",  32'(if_a.finished_all), 32'(exp_fa[0]));
            chk("a_busy",  32'(if_a.busy), 32'(exp_busy[0]));
            chk("a_done",  32'(if_a.done), 32'(exp_done[0]));
            chk("a_error", 32'(if_a.error), 32'(exp_err[0]));
            chk("b_rdy",   32'(if_b.rdy), 32'(exp_rdy[1]));
            chk("b_lstep", if_b.l_step, exp_l[1]);
            chk("b_fprop", 32'(if_b.finished_propagation), 32'(exp_fp[1]));
            chk("b_fall",  32'(if_b.finished_all), 32'(exp_fa[1]));
            chk("b_busy",  32'(if_b.busy), 32'(exp_busy[1]));
            chk("b_done",  32'(if_b.done), 32'(exp_done[1]));
            chk("b_error", 32'(if_b.error), 32'(exp_err[1]));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_for(input int what, input string nm);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
            @(negedge clk);
            case (what)
                0:       hit = (if_a.rdy == '1) && !if_a.finished_propagation && if_a.busy;
                1:       hit = (if_a.rdy == '1) && if_a.finished_propagation && if_a.busy;
                2:       hit = if_a.finished_all;
                3:       hit = if_a.done;
                default: hit = if_a.error;
            endcase
        end
        chk({"wait_", nm}, 32'(hit), 32'd1);
    endtask

    initial begin
        int c0;
        int fa_cnt;
        int n;
        rst_v = '1; start_v = '0;
        fin_v[0] = '0; ff_v[0] = '0; fin_v[1] = '0; ff_v[1] = '0;
        repeat (3) @(negedge clk);
        rst_v = '0;
        chk_en = 1'b1;
        chk("reset_rdy",   32'(if_a.rdy), 32'h0);
        chk("reset_busy",  32'(if_a.busy), 32'h0);
        chk("reset_lstep", if_a.l_step, 32'h0);
        chk("reset_error", 32'(if_a.error), 32'h0);

        // run 1: regular laps, finished 3 cycles into PROP, final 2 into ADDUP
        start_v[0] = 1'b1; c0 = cyc; fa_cnt = 0;
        @(negedge clk); start_v[0] = 1'b0;
        for (int lap = 0; lap < 7; lap++) begin
            wait_for(0, "prop");
            if (lap == 2) start_v[0] = 1'b1;
            repeat (3) @(negedge clk);
            start_v[0] = 1'b0;
            fin_v[0] = '1;
            wait_for(1, "addup");
            fin_v[0] = '0;
            repeat (2) @(negedge clk);
            ff_v[0] = '1;
            wait_for(2, "fall");
            if (if_a.finished_all) fa_cnt++;
            ff_v[0] = '0;
        end
        wait_for(3, "done1");
        chk("r1_cycles", 32'(cyc - c0), 32'd64);
        chk("r1_lstep",  if_a.l_step, 32'd6);
        chk("r1_busy",   32'(if_a.busy), 32'd0);
        chk("r1_fa_pulses", 32'(fa_cnt), 32'd7);

        // run 2: both flag vectors held high throughout -> minimum-length laps
        fin_v[0] = '1; ff_v[0] = '1; start_v[0] = 1'b1; c0 = cyc;
        @(negedge clk); start_v[0] = 1'b0;
        wait_for(3, "done2");
        chk("r2_cycles", 32'(cyc - c0), 32'd29);
        chk("r2_lstep",  if_a.l_step, 32'd6);

        // run 3: staggered single-cycle finished pulses, stale finished_final high
        fin_v[0] = '0; ff_v[0] = '1; start_v[0] = 1'b1;
        @(negedge clk); start_v[0] = 1'b0;
        wait_for(0, "prop3");
        for (int c = 0; c < 15; c++) begin
            if (c == 1) chk("r3_rdy_c1", 32'(if_a.rdy), 32'hFE);
            if (c == 3) chk("r3_rdy_c3", 32'(if_a.rdy), 32'hFC);
            chk("r3_fprop_low", 32'(if_a.finished_propagation), 32'd0);
            fin_v[0] = (c % 2 == 0) ? P'(1 << (c / 2)) : '0;
            @(negedge clk);
        end
        chk("r3_fprop_c15", 32'(if_a.finished_propagation), 32'd1);
        fin_v[0] = '1;
        wait_for(3, "done3");

        // run 4: lane 3 never finishes -> watchdog
        fin_v[0] = '0; ff_v[0] = '0; start_v[0] = 1'b1;
        @(negedge clk); start_v[0] = 1'b0;
        wait_for(0, "prop4");
        fin_v[0] = 8'hF7;
        n = 0;
        for (int i = 1; i <= 40 && n == 0; i++) begin
            @(negedge clk);
            if (if_a.error) n = i;
        end
        chk("r4_err_cycles", 32'(n), 32'd20);
        chk("r4_rdy", 32'(if_a.rdy), 32'h0);
        start_v[0] = 1'b1;
        repeat (2) @(negedge clk);
        chk("r4_err_held", 32'(if_a.error), 32'd1);
        start_v[0] = 1'b0;
        rst_v[0] = 1'b1;
        @(negedge clk); rst_v[0] = 1'b0;
        chk("r4_err_clr", 32'(if_a.error), 32'd0);
        fin_v[0] = '0;

        // run 5: reset in ADDUP at l_step 4, then a fresh run
        start_v[0] = 1'b1;
        @(negedge clk); start_v[0] = 1'b0;
        for (int lap = 0; lap < 5; lap++) begin
            wait_for(0, "prop5");
            fin_v[0] = '1;
            wait_for(1, "addup5");
            fin_v[0] = '0;
            if (lap < 4) begin
                ff_v[0] = '1;
                wait_for(2, "fall5");
                ff_v[0] = '0;
            end
        end
        chk("r5_lstep_pre", if_a.l_step, 32'd4);
        rst_v[0] = 1'b1;
        @(negedge clk); rst_v[0] = 1'b0;
        chk("r5_lstep_rst", if_a.l_step, 32'd0);
        chk("r5_fprop_rst", 32'(if_a.finished_propagation), 32'd0);
        chk("r5_busy_rst",  32'(if_a.busy), 32'd0);
        fin_v[0] = '1; ff_v[0] = '1; start_v[0] = 1'b1;
        @(negedge clk); start_v[0] = 1'b0;
        chk("r5_restart_lstep", if_a.l_step, 32'd0);
        chk("r5_restart_busy",  32'(if_a.busy), 32'd1);
        wait_for(3, "done5");
        chk("r5_final_lstep", if_a.l_step, 32'd6);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // instance B: single lap, start and all flags held high
    initial begin
        int last;
        int pulses;
        last = -1;
        pulses = 0;
        repeat (4) @(negedge clk);
        start_v[1] = 1'b1; fin_v[1] = '1; ff_v[1] = '1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (if_b.done) begin
                if (last >= 0) chk("b_done_period", 32'(i - last), 32'd5);
                chk("b_done_lstep", if_b.l_step, 32'd0);
                last = i;
                pulses++;
            end
        end
        chk("b_done_pulses", 32'(pulses), 32'd12);
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1);
    end
endmodule
